// File: rtl/vblank_write_scheduler_pkg.sv
// Shared types and constants for the vblank write scheduler.
// Holds the engine state enum, command types and transfer sizes.
package vblank_write_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_HEADER,
    ST_DATA,
    ST_TEXT,
    ST_DISCARD
  } state_t;

  typedef enum logic [2:0] {
    CT_HDR    = 3'd0,
    CT_TXT    = 3'd1,
    CT_HEALTH = 3'd2
  } cmd_t;

  localparam int         SPRITE_WORDS = 512;
  localparam int         TEXT_WORDS   = 3;
  localparam logic [6:0] MAX_HEALTH   = 7'd100;

  function automatic logic [6:0] clamp_health(
    input logic [6:0] v
  );
    return (v > MAX_HEALTH) ? MAX_HEALTH : v;
  endfunction

endpackage

// File: rtl/vblank_write_scheduler_fifo.sv
// Single-clock word FIFO feeding the scheduler engine.
// Pushes while full and pops while empty are ignored.
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vblank_write_scheduler.sv
// Drains buffered command words into sprite, palette and text
// RAM write ports, advancing only while vblank is high.
module vblank_write_scheduler
  import vblank_write_scheduler_pkg::*;
#(
  parameter logic [14:0] NUMPIXELSPERSPRITE = 15'd4096,
  parameter logic [4:0]  NUMCOLORSINHEADER  = 5'd16,
  parameter int          FIFO_DEPTH         = 4
) (
  input  logic        vgaclk,
  input  logic        reset_n,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        vblank,
  output logic        pix_we,
  output logic [14:0] pix_addr,
  output logic [3:0]  pix_data,
  output logic        hdr_we,
  output logic [2:0]  hdr_sprite,
  output logic [3:0]  hdr_color,
  output logic [23:0] hdr_rgb,
  output logic        txt_we,
  output logic [3:0]  txt_stream,
  output logic [3:0]  txt_char,
  output logic [7:0]  txt_byte,
  output logic [6:0]  health1,
  output logic [6:0]  health2,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam logic [11:0] HDR_LAST =
    12'(int'(NUMCOLORSINHEADER) - 1);
  localparam logic [11:0] PIX_LAST =
    12'(SPRITE_WORDS * 8 - 1);
  localparam logic [11:0] TXT_LAST =
    12'(TEXT_WORDS * 4 - 1);
  localparam logic [11:0] DSC_LAST =
    12'(int'(NUMCOLORSINHEADER) + SPRITE_WORDS - 1);

  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;
  logic [3:0]  sel, sel_n;
  logic [31:0] head;
  logic        full, empty, pop;
  cmd_t        typ;
  logic [7:0]  err_inc;

  logic        pix_we_n, hdr_we_n, txt_we_n;
  logic [14:0] pix_addr_n;
  logic [3:0]  pix_data_n;
  logic [2:0]  hdr_sprite_n;
  logic [3:0]  hdr_color_n;
  logic [23:0] hdr_rgb_n;
  logic [3:0]  txt_stream_n, txt_char_n;
  logic [7:0]  txt_byte_n;
  logic [6:0]  h1_n, h2_n;
  logic [7:0]  err_n;

  sync_word_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (vgaclk),
    .rst_n(reset_n),
    .push (in_valid),
    .din  (in_word),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign in_ready = reset_n & ~full;
  assign busy     = ~empty | (state != ST_CMD);
  assign typ      = cmd_t'(head[10:8]);
  assign err_inc  = (err_count == 8'hFF) ?
                    err_count : err_count + 8'd1;

  // Next-state and next-output decode for one head-word step.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = sel;
    pop          = 1'b0;
    pix_we_n     = 1'b0;
    pix_addr_n   = pix_addr;
    pix_data_n   = pix_data;
    hdr_we_n     = 1'b0;
    hdr_sprite_n = hdr_sprite;
    hdr_color_n  = hdr_color;
    hdr_rgb_n    = hdr_rgb;
    txt_we_n     = 1'b0;
    txt_stream_n = txt_stream;
    txt_char_n   = txt_char;
    txt_byte_n   = txt_byte;
    h1_n         = health1;
    h2_n         = health2;
    err_n        = err_count;
    if (vblank && !empty) begin
      unique case (state)
        ST_CMD: begin
          pop   = 1'b1;
          sel_n = head[3:0];
          cnt_n = '0;
          unique case (1'b1)
            typ == CT_HDR && !head[3]:
              state_n = ST_HEADER;
            typ == CT_HDR && head[3]: begin
              state_n = ST_DISCARD;
              err_n   = err_inc;
            end
            typ == CT_TXT:
              state_n = ST_TEXT;
            typ == CT_HEALTH: begin
              h1_n = clamp_health(head[30:24]);
              h2_n = clamp_health(head[22:16]);
            end
            default:
              err_n = err_inc;
          endcase
        end
        ST_HEADER: begin
          pop          = 1'b1;
          hdr_we_n     = 1'b1;
          hdr_sprite_n = sel[2:0];
          hdr_color_n  = cnt[3:0];
          hdr_rgb_n    = head[23:0];
          cnt_n        = cnt + 12'd1;
          if (cnt == HDR_LAST) begin
            state_n = ST_DATA;
            cnt_n   = '0;
          end
        end
        ST_DATA: begin
          pix_we_n   = 1'b1;
          pix_addr_n = 15'(sel[2:0]) * NUMPIXELSPERSPRITE
                     + {3'b000, cnt};
          pix_data_n = head[{~cnt[2:0], 2'b00} +: 4];
          pop        = (cnt[2:0] == 3'd7);
          cnt_n      = cnt + 12'd1;
          if (cnt == PIX_LAST) begin
            state_n = ST_CMD;
            cnt_n   = '0;
          end
        end
        ST_TEXT: begin
          txt_we_n     = 1'b1;
          txt_stream_n = sel;
          txt_char_n   = cnt[3:0];
          txt_byte_n   = head[{~cnt[1:0], 3'b000} +: 8];
          pop          = (cnt[1:0] == 2'd3);
          cnt_n        = cnt + 12'd1;
          if (cnt == TXT_LAST) begin
            state_n = ST_CMD;
            cnt_n   = '0;
          end
        end
        ST_DISCARD: begin
          pop   = 1'b1;
          cnt_n = cnt + 12'd1;
          if (cnt == DSC_LAST) begin
            state_n = ST_CMD;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_CMD;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Engine state and registered write ports.
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CMD;
      cnt        <= '0;
      sel        <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      hdr_we     <= 1'b0;
      hdr_sprite <= '0;
      hdr_color  <= '0;
      hdr_rgb    <= '0;
      txt_we     <= 1'b0;
      txt_stream <= '0;
      txt_char   <= '0;
      txt_byte   <= '0;
      health1    <= MAX_HEALTH;
      health2    <= MAX_HEALTH;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      pix_we     <= pix_we_n;
      pix_addr   <= pix_addr_n;
      pix_data   <= pix_data_n;
      hdr_we     <= hdr_we_n;
      hdr_sprite <= hdr_sprite_n;
      hdr_color  <= hdr_color_n;
      hdr_rgb    <= hdr_rgb_n;
      txt_we     <= txt_we_n;
      txt_stream <= txt_stream_n;
      txt_char   <= txt_char_n;
      txt_byte   <= txt_byte_n;
      health1    <= h1_n;
      health2    <= h2_n;
      err_count  <= err_n;
    end
  end

endmodule

// File: tb/tb_vblank_write_scheduler.sv
// Bench for vblank_write_scheduler: command-level model
// expands each command into its expected write stream.
module tb_vblank_write_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        vb_force = 1'b1;
  logic        vb_gen = 1'b1;
  int          vb_mode = 0;
  int          vb_cnt = 0;
  wire         vblank = (vb_mode == 0) ? vb_force : vb_gen;

  logic        in_ready, busy;
  logic        pix_we, hdr_we, txt_we;
  logic [14:0] pix_addr;
  logic [3:0]  pix_data;
  logic [2:0]  hdr_sprite;
  logic [3:0]  hdr_color;
  logic [23:0] hdr_rgb;
  logic [3:0]  txt_stream, txt_char;
  logic [7:0]  txt_byte;
  logic [6:0]  health1, health2;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  vblank_write_scheduler dut (
    .vgaclk    (clk),
    .reset_n   (reset_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vblank    (vblank),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .hdr_we    (hdr_we),
    .hdr_sprite(hdr_sprite),
    .hdr_color (hdr_color),
    .hdr_rgb   (hdr_rgb),
    .txt_we    (txt_we),
    .txt_stream(txt_stream),
    .txt_char  (txt_char),
    .txt_byte  (txt_byte),
    .health1   (health1),
    .health2   (health2),
    .busy      (busy),
    .err_count (err_count)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [14:0] a;
    logic [3:0]  b;
    logic [23:0] c;
  } wr_t;

  typedef struct {
    logic [31:0] w;
    int          h1;
    int          h2;
    int          err;
  } vec_t;

  wr_t  expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pix_seen = 0;
  int   hdr_seen = 0;
  int   txt_seen = 0;
  int   m_h1 = 100;
  int   m_h2 = 100;
  int   m_err = 0;
  logic vb_q = 1'b0;

  function automatic wr_t mk(int k, int a, int b, int c);
    wr_t r;
    r.kind = 2'(k);
    r.a    = 15'(a);
    r.b    = 4'(b);
    r.c    = 24'(c);
    return r;
  endfunction

  always @(posedge clk) vb_q <= vblank;

  always @(posedge clk) begin
    #1;
    vb_cnt++;
    if (vb_mode == 1) begin
      if (vb_cnt % 5 == 0) vb_gen = ~vb_gen;
    end else if (vb_mode == 2) begin
      vb_gen = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin : mon
    wr_t got;
    wr_t exp;
    int  n;
    n = 32'(pix_we) + 32'(hdr_we) + 32'(txt_we);
    if (n != 0) begin
      got = '0;
      if (pix_we) begin
        got = mk(1, int'(pix_addr), int'(pix_data), 0);
        pix_seen++;
      end else if (hdr_we) begin
        got = mk(2, int'(hdr_sprite), int'(hdr_color),
                 int'(hdr_rgb));
        hdr_seen++;
      end else begin
        got = mk(3, int'(txt_stream), int'(txt_char),
                 int'(txt_byte));
        txt_seen++;
      end
      vectors++;
      if (n > 1 || !vb_q) begin
        miscompares++;
        $display("FAIL strobe: %0d strobes, vblank_prev=%0b, need 1 strobe after vblank=1",
                 n, vb_q);
      end else if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got %h, none expected", got);
      end else begin
        exp = expq.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL write: got %h expected %h", got, exp);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_word  = w;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready=0 after %0d cycles", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while ((busy || expq.size() != 0) && t < budget);
    vectors++;
    if (busy || expq.size() != 0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%0b pending=%0d, need idle",
               name, busy, expq.size());
    end
  endtask

  task automatic send_health(input int h1, input int h2,
                             input int gap);
    logic [31:0] w;
    w = {1'b0, 7'(h1), 1'b0, 7'(h2), 16'h0200};
    m_h1 = (h1 > 100) ? 100 : h1;
    m_h2 = (h2 > 100) ? 100 : h2;
    push_word(w, gap);
  endtask

  task automatic send_bad(input int typ, input int gap);
    logic [31:0] w;
    w = $urandom;
    w[10:8] = 3'(typ);
    m_err = (m_err < 255) ? m_err + 1 : 255;
    push_word(w, gap);
  endtask

  task automatic send_discard(input int gap);
    logic [31:0] w;
    w = $urandom;
    w[10:8] = 3'd0;
    w[3] = 1'b1;
    m_err = (m_err < 255) ? m_err + 1 : 255;
    push_word(w, gap);
    for (int i = 0; i < 528; i++)
      push_word($urandom, $urandom_range(0, gap));
  endtask

  task automatic send_text(input int stream,
                           input logic [95:0] s,
                           input int gap);
    for (int k = 0; k < 12; k++)
      expq.push_back(mk(3, stream % 16, k,
                        int'(s[95-8*k -: 8])));
    push_word(32'h0000_0100 | 32'(stream % 16), gap);
    for (int t = 0; t < 3; t++)
      push_word(s[95-32*t -: 32], $urandom_range(0, gap));
  endtask

  task automatic send_sprite(input int spr, input int gap,
                             input int nwords, input bit rnd);
    logic [31:0] rgbw [16];
    logic [31:0] d [512];
    int          p;
    for (int c = 0; c < 16; c++) begin
      rgbw[c] = $urandom;
      expq.push_back(mk(2, spr, c, int'(rgbw[c][23:0])));
    end
    for (int i = 0; i < nwords; i++) begin
      d[i] = rnd ? $urandom : 32'h0123_4567;
      for (int n = 0; n < 8; n++) begin
        p = i * 8 + n;
        expq.push_back(mk(1, (spr * 4096 + p) % 32768,
                          int'((d[i] >> (28 - 4*n)) & 32'hF), 0));
      end
    end
    push_word(32'(spr), gap);
    for (int c = 0; c < 16; c++)
      push_word(rgbw[c], $urandom_range(0, gap));
    for (int i = 0; i < nwords; i++)
      push_word(d[i], $urandom_range(0, gap));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", {29'd0, pix_we, hdr_we, txt_we}, 0);
    chk("rst_pix", {13'd0, pix_addr, pix_data}, 0);
    chk("rst_hdr", {1'b0, hdr_sprite, hdr_color, hdr_rgb}, 0);
    chk("rst_txt", {16'd0, txt_stream, txt_char, txt_byte}, 0);
    chk("rst_health1", 32'(health1), 100);
    chk("rst_health2", 32'(health2), 100);
    chk("rst_err", 32'(err_count), 0);
    expq.delete();
    m_h1 = 100;
    m_h2 = 100;
    m_err = 0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_release", 32'(in_ready), 1);
  endtask

  vec_t tab [9];

  initial begin
    int p0;
    int h0;
    int t;
    tab[0] = '{32'h7F32_0200, 100, 50, 0};
    tab[1] = '{32'h0A14_0200, 10, 20, 0};
    tab[2] = '{32'h6564_0200, 100, 100, 0};
    tab[3] = '{32'h0000_0300, 100, 100, 1};
    tab[4] = '{32'h6300_0200, 99, 0, 1};
    tab[5] = '{32'hFFFF_0700, 99, 0, 2};
    tab[6] = '{32'h0000_0405, 99, 0, 3};
    tab[7] = '{32'h0042_0200, 0, 66, 3};
    tab[8] = '{32'hFFFF_0200, 100, 100, 3};

    do_reset();

    vb_mode  = 0;
    vb_force = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_word(tab[i].w, 0);
      wait_idle("tab", 100);
      chk($sformatf("tab%0d_h1", i), 32'(health1), tab[i].h1);
      chk($sformatf("tab%0d_h2", i), 32'(health2), tab[i].h2);
      chk($sformatf("tab%0d_err", i), 32'(err_count), tab[i].err);
    end
    m_h1  = tab[8].h1;
    m_h2  = tab[8].h2;
    m_err = tab[8].err;

    h0 = txt_seen;
    send_text(2, "ABCDEFGHIJKL", 0);
    wait_idle("text", 200);
    chk("text_strobes", 32'(txt_seen - h0), 12);

    p0 = pix_seen;
    h0 = hdr_seen;
    send_sprite(3, 0, 512, 1'b0);
    wait_idle("sprite", 20000);
    chk("sprite_pix_strobes", 32'(pix_seen - p0), 4096);
    chk("sprite_hdr_strobes", 32'(hdr_seen - h0), 16);

    vb_force = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_word = {1'b0, 7'((i+1)*10), 1'b0,
                 7'((i+1)*10+5), 16'h0200};
      @(posedge clk);
      #1;
    end
    chk("in_ready_full", 32'(in_ready), 0);
    in_word = {1'b0, 7'd50, 1'b0, 7'd55, 16'h0200};
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("in_ready_hold", 32'(in_ready), 0);
    chk("busy_full", 32'(busy), 1);
    chk("health_held", 32'(health1), 100);
    vb_force = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_pop", 32'(in_ready), 1);
    chk("health_first_pop", 32'(health1), 10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_h1 = 50;
    m_h2 = 55;
    wait_idle("fill", 200);
    chk("fill_h1", 32'(health1), m_h1);
    chk("fill_h2", 32'(health2), m_h2);

    vb_mode = 1;
    p0 = pix_seen;
    send_sprite(3, 0, 512, 1'b0);
    wait_idle("toggle", 20000);
    chk("toggle_pix_strobes", 32'(pix_seen - p0), 4096);

    vb_mode = 2;
    for (int i = 0; i < 14; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (i == 4)
        send_sprite($urandom_range(0, 7), 1, 512, 1'b1);
      else if (i == 9)
        send_discard(1);
      else if (k < 4)
        send_health($urandom_range(0, 127),
                    $urandom_range(0, 127), 2);
      else if (k < 7)
        send_text($urandom_range(0, 15),
                  {$urandom, $urandom, $urandom}, 2);
      else
        send_bad($urandom_range(3, 7), 2);
    end
    wait_idle("random", 30000);
    chk("rand_h1", 32'(health1), m_h1);
    chk("rand_h2", 32'(health2), m_h2);
    chk("rand_err", 32'(err_count), m_err);

    vb_mode  = 0;
    vb_force = 1'b1;
    for (int i = 0; i < 260; i++)
      send_bad(3 + i % 5, 0);
    wait_idle("sat", 500);
    chk("err_saturate", 32'(err_count), 255);
    chk("err_model", 32'(m_err), 255);

    p0 = pix_seen;
    send_sprite(5, 0, 13, 1'b1);
    t = 0;
    while (pix_seen - p0 < 100 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("reach_100_pixels", 32'(pix_seen - p0 >= 100), 1);
    do_reset();
    p0 = pix_seen;
    send_health(30, 40, 0);
    wait_idle("post_reset", 200);
    chk("post_reset_h1", 32'(health1), 30);
    chk("post_reset_h2", 32'(health2), 40);
    repeat (50) @(posedge clk);
    #1;
    chk("no_pix_after_reset", 32'(pix_seen - p0), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
